// File: rtl/func_out_pkt_buf.sv
// func_out_pkt_buf
// Output-side packet buffer behind the kernel wrapper. Coalesced result words
// are stored in a small first-word-fall-through FIFO and re-emitted as an
// AXI4-Stream. tlast marks the final word of a host-programmed length.
// A start/busy/done handshake serves the kernel controller.

module func_out_pkt_buf #(
  parameter int C_DATA_WIDTH = 128,
  parameter int DEPTH        = 16,
  parameter int CNT_W        = 32
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     ctrl_start,
  input  logic [CNT_W-1:0]         ctrl_len,
  output logic                     ctrl_busy,
  output logic                     ctrl_done,
  input  logic                     s_tvalid,
  input  logic [C_DATA_WIDTH-1:0]  s_tdata,
  output logic                     s_tready,
  output logic                     m_tvalid,
  output logic [C_DATA_WIDTH-1:0]  m_tdata,
  output logic                     m_tlast,
  input  logic                     m_tready,
  output logic [$clog2(DEPTH):0]   fill_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;

  localparam logic [FW-1:0]    FULL_LVL = FW'(DEPTH);
  localparam logic [FW-1:0]    FILL_ONE = FW'(1);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_len;
  logic [CNT_W-1:0]        r_in_cnt;
  logic [CNT_W-1:0]        r_out_cnt;
  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_rd_ptr;
  logic [FW-1:0]           r_fill;
  logic [C_DATA_WIDTH-1:0] r_mem [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_in_room;
  logic w_last_out;
  logic w_push;
  logic w_pop;

  // Flow-control terms derived only from registered state, so s_tready never
  // depends combinationally on m_tready. A full FIFO refuses a push even in a
  // cycle that also pops.
  assign w_full     = (r_fill == FULL_LVL);
  assign w_empty    = (r_fill == '0);
  assign w_in_room  = (r_in_cnt != r_len);
  assign w_last_out = (r_out_cnt == (r_len - CNT_ONE));

  assign s_tready   = (r_state == ST_RUN) && !w_full && w_in_room;
  assign m_tvalid   = !w_empty;
  assign m_tlast    = m_tvalid && w_last_out;
  // The storage array is not cleared by reset, so the head entry is masked
  // whenever nothing valid is buffered; this keeps m_tdata at 0 after reset.
  assign m_tdata    = m_tvalid ? r_mem[r_rd_ptr] : '0;

  assign w_push     = s_tvalid && s_tready;
  assign w_pop      = m_tvalid && m_tready;

  assign ctrl_busy  = (r_state != ST_IDLE);
  assign ctrl_done  = (r_state == ST_DONE);
  assign fill_level = r_fill;

  // Transfer control: IDLE/RUN/DONE sequencing plus the length and word counters.
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update from the same pre-edge values, independent of block ordering.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state   <= ST_IDLE;
      r_len     <= '0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ctrl_start) begin
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            if (ctrl_len != '0) begin
              r_len   <= ctrl_len;
              r_state <= ST_RUN;
            end else begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          if (w_push) begin
            r_in_cnt <= r_in_cnt + CNT_ONE;
          end
          if (w_pop) begin
            r_out_cnt <= r_out_cnt + CNT_ONE;
            if (w_last_out) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // FIFO bookkeeping: wrapping pointers and an occupancy count that holds on
  // a simultaneous push and pop.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + FILL_ONE;
        2'b01:   r_fill <= r_fill - FILL_ONE;
        default: r_fill <= r_fill;
      endcase
    end
  end

  // Word storage written at the write pointer on each accepted input word.
  // NOTE: the array has no reset; clearing the pointers and occupancy already
  // marks every entry stale, and a reset-free array maps onto plain RAM/flops.
  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= s_tdata;
    end
  end

endmodule

// File: tb/tb_func_out_pkt_buf.sv
// Testbench for func_out_pkt_buf.
// The stimulus process drives control and stream inputs. An input-side monitor
// keeps a reference model of the transfer and pushes expected words into a
// scoreboard queue. An output-side monitor pops the queue and compares the
// queued word with every output handshake.

module tb_func_out_pkt_buf;

  localparam int DW    = 128;
  localparam int DEPTH = 16;
  localparam int CW    = 32;
  localparam int FW    = $clog2(DEPTH) + 1;

  logic          aclk       = 1'b0;
  logic          areset     = 1'b1;
  logic          ctrl_start = 1'b0;
  logic [CW-1:0] ctrl_len   = '0;
  logic          ctrl_busy;
  logic          ctrl_done;
  logic          s_tvalid   = 1'b0;
  logic [DW-1:0] s_tdata    = '0;
  logic          s_tready;
  logic          m_tvalid;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic          m_tready   = 1'b0;
  logic [FW-1:0] fill_level;

  func_out_pkt_buf #(
    .C_DATA_WIDTH (DW),
    .DEPTH        (DEPTH),
    .CNT_W        (CW)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .ctrl_start (ctrl_start),
    .ctrl_len   (ctrl_len),
    .ctrl_busy  (ctrl_busy),
    .ctrl_done  (ctrl_done),
    .s_tvalid   (s_tvalid),
    .s_tdata    (s_tdata),
    .s_tready   (s_tready),
    .m_tvalid   (m_tvalid),
    .m_tdata    (m_tdata),
    .m_tlast    (m_tlast),
    .m_tready   (m_tready),
    .fill_level (fill_level)
  );

  always #5 aclk = ~aclk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the transfer phase, the latched length and a queue that
  // holds exactly the words that should currently be buffered.
  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  typedef enum int {M_IDLE, M_RUN, M_DONE} mphase_t;

  exp_t          exp_q[$];
  mphase_t       m_phase  = M_IDLE;
  logic [CW-1:0] m_len    = '0;
  logic [CW-1:0] m_acc    = '0;
  int            fill_now = 0;

  // Input-side monitor: runs on the falling edge, when the inputs for the
  // next rising edge are stable.
  always @(negedge aclk) begin
    if (areset) begin
      exp_q.delete();
      m_phase  = M_IDLE;
      m_acc    = '0;
      fill_now = 0;
    end else begin
      fill_now = exp_q.size();
      check("fill_level", DW'(fill_level), DW'(fill_now));
      check("s_tready", DW'(s_tready),
            DW'(m_phase == M_RUN && m_acc != m_len && fill_now < DEPTH));
      check("ctrl_busy", DW'(ctrl_busy), DW'(m_phase != M_IDLE));
      check("ctrl_done", DW'(ctrl_done), DW'(m_phase == M_DONE));
      if (s_tvalid && s_tready) begin
        exp_t e;
        e.data = s_tdata;
        e.last = (m_acc == m_len - 1);
        exp_q.push_back(e);
        m_acc = m_acc + 1;
      end
      case (m_phase)
        M_IDLE: begin
          if (ctrl_start) begin
            m_acc = '0;
            if (ctrl_len != '0) begin
              m_len   = ctrl_len;
              m_phase = M_RUN;
            end else begin
              m_phase = M_DONE;
            end
          end
        end
        M_DONE:  m_phase = M_IDLE;
        default: ;
      endcase
    end
  end

  // Output-side monitor: pops the scoreboard on each output handshake and
  // checks that a stalled word holds steady.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  logic          prev_last  = 1'b0;

  always begin
    @(negedge aclk);
    #1;
    if (areset) begin
      prev_stall = 1'b0;
    end else begin
      check("m_tvalid", DW'(m_tvalid), DW'(fill_now != 0));
      if (!m_tvalid) begin
        check("m_tlast_idle", DW'(m_tlast), DW'(0));
      end
      if (prev_stall) begin
        check("stall_data", m_tdata, prev_data);
        check("stall_last", DW'(m_tlast), DW'(prev_last));
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_word: got %h, expected no output word", m_tdata);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_data", m_tdata, e.data);
          check("out_last", DW'(m_tlast), DW'(e.last));
          if (e.last) m_phase = M_DONE;
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
    end
  end

  // Stimulus tasks. Inputs change 1 time unit after the rising edge.
  task automatic do_reset();
    @(posedge aclk); #1;
    areset     = 1'b1;
    s_tvalid   = 1'b0;
    ctrl_start = 1'b0;
    @(posedge aclk); #1;
    check("rst_s_tready",   DW'(s_tready),   DW'(0));
    check("rst_m_tvalid",   DW'(m_tvalid),   DW'(0));
    check("rst_m_tlast",    DW'(m_tlast),    DW'(0));
    check("rst_m_tdata",    m_tdata,         DW'(0));
    check("rst_ctrl_busy",  DW'(ctrl_busy),  DW'(0));
    check("rst_ctrl_done",  DW'(ctrl_done),  DW'(0));
    check("rst_fill_level", DW'(fill_level), DW'(0));
    areset = 1'b0;
  endtask

  task automatic start(input logic [CW-1:0] len);
    @(posedge aclk); #1;
    ctrl_start = 1'b1;
    ctrl_len   = len;
    @(posedge aclk); #1;
    ctrl_start = 1'b0;
  endtask

  // Offers words first..last-1 (valid held until accepted). pv/pr are the
  // percentages for s_tvalid and m_tready. mid_start >= 0 pulses ctrl_start
  // on that cycle. Returns the index of the next unaccepted word.
  task automatic drive(input int first, input int last, input bit seq,
                       input int pv, input int pr, input int limit,
                       input int mid_start, output int next_idx);
    int idx;
    bit pend;
    idx  = first;
    pend = 1'b0;
    for (int cyc = 0; cyc < limit && idx < last; cyc++) begin
      @(posedge aclk); #1;
      if (!pend) begin
        pend    = ($urandom_range(99) < pv);
        s_tdata = seq ? DW'(idx + 1) : {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      s_tvalid = pend;
      m_tready = ($urandom_range(99) < pr);
      if (cyc == mid_start) begin
        ctrl_start = 1'b1;
        ctrl_len   = 32'd7;
      end else begin
        ctrl_start = 1'b0;
      end
      @(negedge aclk);
      if (s_tvalid && s_tready) begin
        pend = 1'b0;
        idx++;
      end
    end
    next_idx = idx;
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) begin
      @(posedge aclk); #1;
      s_tvalid   = 1'b0;
      ctrl_start = 1'b0;
      m_tready   = rdy;
    end
  endtask

  task automatic drain(input int pr, input int limit);
    int cyc;
    cyc = 0;
    do begin
      @(posedge aclk); #1;
      s_tvalid   = 1'b0;
      ctrl_start = 1'b0;
      m_tready   = ($urandom_range(99) < pr);
      @(negedge aclk);
      cyc++;
    end while (ctrl_busy && cyc < limit);
    check("drain_idle", DW'(ctrl_busy), DW'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int idx;
    do_reset();

    // Basic transfer of four sequential words.
    start(32'd4);
    drive(0, 4, 1'b1, 100, 100, 20, -1, idx);
    check("basic_taken", DW'(idx), DW'(4));
    drain(100, 50);

    // Back-pressure: only DEPTH words fit while the sink stalls.
    start(32'd20);
    drive(0, 20, 1'b1, 100, 0, 40, -1, idx);
    check("bp_taken", DW'(idx), DW'(16));
    check("bp_fill", DW'(fill_level), DW'(16));
    check("bp_ready", DW'(s_tready), DW'(0));
    drive(idx, 20, 1'b1, 100, 100, 60, -1, idx);
    check("bp_taken_all", DW'(idx), DW'(20));
    drain(100, 60);

    // Over-supply: five words offered, three consumed.
    start(32'd3);
    drive(0, 5, 1'b1, 100, 100, 12, -1, idx);
    check("os_taken", DW'(idx), DW'(3));
    check("os_ready", DW'(s_tready), DW'(0));
    drain(100, 30);

    // Zero-length transfer: done pulse only.
    start(32'd0);
    drain(100, 10);

    // Start pulsed mid-transfer is ignored.
    start(32'd6);
    drive(0, 6, 1'b0, 80, 70, 100, 2, idx);
    check("mid_start_taken", DW'(idx), DW'(6));
    drain(70, 100);

    // Reset after five pushes and two pops, then a clean short transfer.
    start(32'd10);
    drive(0, 5, 1'b1, 100, 0, 20, -1, idx);
    check("rm_taken", DW'(idx), DW'(5));
    idle(2, 1'b1);
    idle(1, 1'b0);
    @(negedge aclk);
    check("rm_fill", DW'(fill_level), DW'(3));
    do_reset();
    start(32'd2);
    drive(100, 102, 1'b1, 100, 100, 20, -1, idx);
    check("rm_new_taken", DW'(idx), DW'(102));
    drain(100, 30);

    // Random stall soak, long enough to wrap the pointers many times.
    start(32'd1000);
    drive(0, 1000, 1'b0, 50, 50, 20000, -1, idx);
    check("soak_taken", DW'(idx), DW'(1000));
    drain(50, 300);

    idle(3, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/func_out_pkt_buf.md
# func_out_pkt_buf

Output-side packet buffer that sits directly downstream of `func_hdl_top`. It consumes the coalesced result stream (`m_tvalid`/`m_tdata`/`m_tready` of the kernel wrapper), stores it in a small FIFO and re-emits it as an AXI4-Stream with `tlast` asserted on the final word of a host-programmed transfer length. It also provides start/busy/done control for the SDx kernel controller, and it decouples kernel back-pressure from the memory-write datamover.

## Interface
- `C_DATA_WIDTH`, 128: width of one coalesced word. Matches the kernel wrapper output (4 × 32-bit streams).
- `DEPTH`, 16: FIFO depth in words. Must be a power of two, ≥ 2.
- `CNT_W`, 32: width of the length and word counters.

Ports:
- `aclk`  in  1: clock.
- `areset`  in  1: reset, synchronous, active-high. Single clock domain.
- `ctrl_start`  in  1: one-cycle pulse that begins a transfer. Ignored unless in IDLE.
- `ctrl_len`  in  CNT_W: number of words in the transfer. Sampled on an accepted `ctrl_start`.
- `ctrl_busy`  out  1: high in RUN and DONE.
- `ctrl_done`  out  1: one-cycle pulse issued after the last output handshake.
- `s_tvalid`  in  1: input word valid, driven by the kernel wrapper's `m_tvalid`.
- `s_tdata`  in  C_DATA_WIDTH: input word.
- `s_tready`  out  1: buffer accepts a word.
- `m_tvalid`  out  1: output word valid.
- `m_tdata`  out  C_DATA_WIDTH: output word.
- `m_tlast`  out  1: marks the final word of the transfer.
- `m_tready`  in  1: downstream sink ready.
- `fill_level`  out  $clog2(DEPTH)+1: current FIFO occupancy, 0..DEPTH.

## Operation
- **State machine:** IDLE, RUN, DONE.
  - IDLE → RUN on `ctrl_start` with `ctrl_len` ≠ 0. Latch `len`; clear `in_cnt` and `out_cnt`.
  - IDLE → DONE on `ctrl_start` with `ctrl_len` = 0. No data moves.
  - RUN → DONE on the output handshake where `out_cnt` = `len`−1.
  - DONE → IDLE unconditionally after one cycle. `ctrl_done` = 1 only while in DONE.
- **Input side:**
  - `s_tready` = (state == RUN) && !full && (`in_cnt` ≠ `len`).
  - Push on `s_tvalid` && `s_tready`; `in_cnt` += 1.
  - Words beyond `len` are not consumed: `s_tready` stays low and the data is held upstream.
- **Full condition:** full = (`fill_level` == DEPTH). There is no same-cycle pop-to-push bypass, so when full, `s_tready` = 0 even if a pop is occurring. `s_tready` has no combinational path from `m_tready`.
- **Output side:**
  - `m_tvalid` = (`fill_level` ≠ 0). `m_tdata` = the FIFO entry at `rd_ptr` (first-word fall-through).
  - `m_tlast` = `m_tvalid` && (`out_cnt` == `len`−1).
  - Pop on `m_tvalid` && `m_tready`; `out_cnt` += 1.
  - `m_tdata`/`m_tlast` stay stable while `m_tvalid` && !`m_tready`.
- **FIFO structure:**
  - Register array of DEPTH entries.
  - `wr_ptr`/`rd_ptr` are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - `fill_level` +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- **Counter widths:** both counters are CNT_W bits. `len` up to 2^CNT_W−1 is legal, with no wrap within a transfer.
- **Control:** `ctrl_start` during RUN or DONE is ignored; `len` is not re-latched.
- **Reset (any state, including mid-transfer):**
  - State → IDLE; pointers, counters and `fill_level` → 0.
  - Buffered data is discarded.
  - Every output reads 0 in the cycle after `areset` is sampled high.

## Timing
- **Reset values:** `s_tready`=0, `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0, `ctrl_busy`=0, `ctrl_done`=0, `fill_level`=0.
- **Start to ready:** `ctrl_start` accepted at edge t → RUN and `s_tready`=1 from t+1.
- **Latency:** a word pushed at edge t gives `m_tvalid`=1 from t+1 (1 cycle, empty FIFO).
- **Throughput:** 1 word/cycle sustained while `m_tready`=1 and input is available.
- **Done pulse:** last output handshake at edge t → `ctrl_done`=1 during cycle t+1 → IDLE at t+2 (`ctrl_busy` low from t+2).
- **Zero-length transfer:** `ctrl_start` with `len`=0 at t → `ctrl_done`=1 during t+1.

## Test plan
- **Basic transfer:** `ctrl_len`=4, inputs 0x…01..0x…04 back-to-back, `m_tready`=1 → outputs 01..04 in order, each one cycle after input. `m_tlast` only on 04. `ctrl_done` one cycle after the 04 handshake.
- **Back-pressure / full:** `ctrl_len`=20, `m_tready`=0 → exactly 16 words accepted, `fill_level`=16, `s_tready`=0. Release `m_tready` → all 20 words out in order, `m_tlast` on word 20, no loss or duplication.
- **Over-supply:** `ctrl_len`=3, `s_tvalid` held high with 5 words → only 3 consumed, `s_tready` low after the third. The 4th word stays on `s_tdata`.
- **Zero length and ignored start:** `ctrl_len`=0 → `ctrl_done` pulse next cycle, no `m_tvalid`. `ctrl_start` pulsed mid-RUN → `len` unchanged, transfer completes normally.
- **Reset mid-transfer:** `ctrl_len`=10, reset after 5 pushes and 2 pops → all outputs 0 next cycle, `fill_level`=0. A new `ctrl_len`=2 transfer completes cleanly.
- **Random stall soak:** random `s_tvalid`/`m_tready` at 50% duty, `ctrl_len`=1000 → scoreboard matches in order, with pointer wrap exercised more than 60 times.
